// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-requester register-file write-port arbiter with anti-starvation and a registered write stage
module regfile_wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] wrt_data,
  output logic [15:0]       stall_cnt
);
  logic              grant_a, grant_b, refused;
  logic [3:0]        starve_q, starve_d;
  logic [15:0]       stall_q, stall_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  // A wins ties unless B has been refused long enough; write stage captures the winner, x0 never enables the write
  always_comb begin
    grant_b    = !rst && b_valid && (!a_valid || starve_q >= 4'(STARVE_MAX));
    grant_a    = !rst && a_valid && !grant_b;
    refused    = (a_valid && !grant_a) || (b_valid && !grant_b);
    starve_d   = (rst || !b_valid || grant_b) ? 4'd0 : (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
    stall_d    = rst ? 16'd0 : (refused && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    regwrite_d = (grant_a && a_rd != '0) || (grant_b && b_rd != '0);
    rd_d       = rst ? '0 : grant_a ? a_rd : grant_b ? b_rd : rd_q;
    data_d     = rst ? '0 : grant_a ? a_data : grant_b ? b_data : data_q;
  end
  // state and write-stage registers
  always_ff @(posedge clk) begin
    starve_q   <= starve_d;
    stall_q    <= stall_d;
    regwrite_q <= regwrite_d;
    rd_q       <= rd_d;
    data_q     <= data_d;
  end
  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign RegWrite  = regwrite_q;
  assign rd        = rd_q;
  assign wrt_data  = data_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed plus randomized checks of the write-port arbiter against a behavioural model
module tb_regfile_wb_arbiter;
  localparam int SM = 4;
  logic        clk = 1'b0;
  logic        rst, a_valid, b_valid, a_ready, b_ready, RegWrite;
  logic [4:0]  a_rd, b_rd, rd;
  logic [63:0] a_data, b_data, wrt_data;
  logic [15:0] stall_cnt;
  regfile_wb_arbiter #(.DATA_W(64), .ADDR_W(5), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .RegWrite(RegWrite), .rd(rd), .wrt_data(wrt_data), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  logic [63:0] rf [32] = '{default: 64'd0};
  always @(posedge clk) if (RegWrite) rf[rd] <= wrt_data;
  int          n_checks = 0, n_fail = 0;
  int          m_starve, m_stall;
  logic        m_we, last_ga, last_gb;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  logic [63:0] m_regs [32] = '{default: 64'd0};
  string       seq;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_s(input string tag, input string obs, input string exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    logic ga, gb;
    #1;
    gb = !rst && b_valid && (!a_valid || m_starve >= SM);
    ga = !rst && a_valid && !gb;
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    if (a_ready) seq = {seq, "A"};
    else if (b_ready) seq = {seq, "B"};
    else seq = {seq, "-"};
    last_ga = ga;
    last_gb = gb;
    @(posedge clk);
    #1;
    if (rst) begin
      m_starve = 0; m_stall = 0; m_we = 0; m_rd = 0; m_data = 0;
    end else begin
      if (((a_valid && !ga) || (b_valid && !gb)) && m_stall < 65535) m_stall++;
      m_starve = (!b_valid || gb) ? 0 : (m_starve < 15 ? m_starve + 1 : 15);
      m_we = 0;
      if (ga) begin m_rd = a_rd; m_data = a_data; m_we = (a_rd != 0); end
      else if (gb) begin m_rd = b_rd; m_data = b_data; m_we = (b_rd != 0); end
      if (m_we) m_regs[m_rd] = m_data;
    end
    chk("RegWrite", RegWrite, m_we);
    chk("rd", rd, m_rd);
    chk("wrt_data", wrt_data, m_data);
    chk("stall_cnt", stall_cnt, m_stall);
  endtask
  initial begin
    rst = 1; a_valid = 0; b_valid = 0; a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
    m_starve = 0; m_stall = 0; m_we = 0; m_rd = 0; m_data = 0; seq = "";
    repeat (2) cycle();
    rst = 0;
    repeat (5) cycle();
    chk("idle_we", RegWrite, 0);
    chk("idle_stall", stall_cnt, 0);
    a_valid = 1; a_rd = 5; a_data = -64'sd7;
    cycle();
    chk("a_we", RegWrite, 1);
    chk("a_rd", rd, 5);
    chk("a_data", wrt_data, 64'hFFFF_FFFF_FFFF_FFF9);
    a_valid = 0;
    cycle();
    chk("a_we_off", RegWrite, 0);
    b_valid = 1; b_rd = 0; b_data = 123;
    cycle();
    chk("x0_we", RegWrite, 0);
    chk("x0_rd", rd, 0);
    chk("x0_data", wrt_data, 123);
    b_valid = 0;
    cycle();
    seq = ""; a_valid = 1; b_valid = 1; a_rd = 7; b_rd = 9; a_data = 100; b_data = 200;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_ga) a_data = a_data + 1;
      if (last_gb) b_data = b_data + 1;
    end
    chk_s("contention_seq", seq, "AAAABAAAAB");
    chk("contention_stall", stall_cnt, 10);
    a_valid = 0; b_valid = 0;
    cycle();
    a_valid = 1; b_valid = 1; a_rd = 3; b_rd = 3; a_data = 1; b_data = 2;
    cycle();
    chk("same_first", wrt_data, 1);
    a_valid = 0;
    cycle();
    chk("same_second", wrt_data, 2);
    b_valid = 0;
    repeat (2) cycle();
    chk("x3_final", rf[3], 2);
    seq = ""; a_valid = 1; b_valid = 1; a_rd = 10; b_rd = 11; a_data = 500; b_data = 600;
    for (int i = 1; i <= 11; i++) begin
      rst = (i == 6);
      cycle();
      if (i == 6) begin
        chk("rst_we", RegWrite, 0);
        chk("rst_rd", rd, 0);
        chk("rst_data", wrt_data, 0);
        chk("rst_stall", stall_cnt, 0);
      end
      if (last_ga) a_data = a_data + 1;
      if (last_gb) b_data = b_data + 1;
    end
    rst = 0;
    chk_s("rst_mid_seq", seq, "AAAAB-AAAAB");
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!a_valid && $urandom_range(0, 2) != 0) begin
        a_valid = 1; a_rd = 5'($urandom_range(0, 31)); a_data = {$urandom, $urandom};
      end
      if (!b_valid && $urandom_range(0, 2) == 0) begin
        b_valid = 1; b_rd = 5'($urandom_range(0, 31)); b_data = {$urandom, $urandom};
      end
      cycle();
      if (last_ga) a_valid = 0;
      if (last_gb) b_valid = 0;
    end
    rst = 0; a_valid = 0; b_valid = 0;
    repeat (2) cycle();
    for (int r = 0; r < 32; r++) chk($sformatf("rf_x%0d", r), rf[r], m_regs[r]);
    rst = 1;
    cycle();
    rst = 0; a_valid = 1; b_valid = 1;
    repeat (65540) @(posedge clk);
    #1;
    chk("stall_sat", stall_cnt, 16'hFFFF);
    rst = 1; a_valid = 0; b_valid = 0;
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
